// File: rtl/qsys_cpu_cpu_mult_unit_if.sv
// Handshake bundle for the pipelined multiplier.
//   master : operand producer / result consumer (core or coprocessor port)
//   slave  : the multiplier itself
// Signals:
//   in_valid/in_ready   operand transfer handshake
//   in_src1, in_src2    operands A (rA) and B (rB)
//   in_op               00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//   out_valid/out_ready result transfer handshake
//   out_result          selected product word
interface qsys_cpu_cpu_mult_unit_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;

  modport master (
    output in_valid, in_src1, in_src2, in_op, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_src1, in_src2, in_op, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/qsys_cpu_cpu_mult_unit.sv
// Three-stage pipelined integer multiplier with valid/ready flow control.
//   S1: four half-width partial products, plus A, B and op
//   S2: full-width sum of partial products and signed correction terms
//   S3: correction applied, low or high word selected
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      slave side of qsys_cpu_cpu_mult_unit_if
// The whole pipe advances together; a stalled result freezes every stage,
// so in_ready is a combinational function of out_ready.
module qsys_cpu_cpu_mult_unit #(
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  qsys_cpu_cpu_mult_unit_if.slave     bus
);
  localparam int SLICE_W = DATA_W / 2;
  localparam int P_W     = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  logic              s1_valid, s2_valid, s3_valid;
  logic [DATA_W-1:0] s1_ll, s1_lh, s1_hl, s1_hh;
  logic [DATA_W-1:0] s1_a, s1_b;
  op_e               s1_op, s2_op;
  logic [P_W-1:0]    s2_p, s2_ca, s2_cb;
  logic [DATA_W-1:0] s3_result;

  logic              adv;
  logic [SLICE_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [P_W-1:0]    p_sum, ca, cb, r_full;
  logic [DATA_W-1:0] r_word;

  assign adv = ~s3_valid | bus.out_ready;

  assign bus.in_ready   = adv;
  assign bus.out_valid  = s3_valid;
  // Data registers of empty stages are don't-care, so the output is masked.
  assign bus.out_result = s3_valid ? s3_result : '0;

  assign a_lo = bus.in_src1[SLICE_W-1:0];
  assign a_hi = bus.in_src1[DATA_W-1:SLICE_W];
  assign b_lo = bus.in_src2[SLICE_W-1:0];
  assign b_hi = bus.in_src2[DATA_W-1:SLICE_W];

  // Middle products are widened before adding so their carry survives.
  always_comb begin
    p_sum = (P_W'(s1_hh) << DATA_W)
          + ((P_W'(s1_lh) + P_W'(s1_hl)) << SLICE_W)
          + P_W'(s1_ll);
    ca = '0;
    cb = '0;
    if ((s1_op == OP_MULXSS || s1_op == OP_MULXSU) && s1_a[DATA_W-1])
      ca = {s1_b, {DATA_W{1'b0}}};
    if (s1_op == OP_MULXSS && s1_b[DATA_W-1])
      cb = {s1_a, {DATA_W{1'b0}}};
  end

  always_comb begin
    r_full = s2_p - s2_ca - s2_cb;
    r_word = (s2_op == OP_MUL) ? r_full[DATA_W-1:0] : r_full[P_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_ll     <= DATA_W'(a_lo) * DATA_W'(b_lo);
      s1_lh     <= DATA_W'(a_lo) * DATA_W'(b_hi);
      s1_hl     <= DATA_W'(a_hi) * DATA_W'(b_lo);
      s1_hh     <= DATA_W'(a_hi) * DATA_W'(b_hi);
      s1_a      <= bus.in_src1;
      s1_b      <= bus.in_src2;
      s1_op     <= op_e'(bus.in_op);
      s2_p      <= p_sum;
      s2_ca     <= ca;
      s2_cb     <= cb;
      s2_op     <= s1_op;
      s3_result <= r_word;
    end
  end
endmodule
